// File: rtl/vga_sync_rx.sv
// ---------------------------------------------------------------------------
// vga_sync_rx
//
// Receiving end of the 640x480@60 VGA timing interface. Takes the active-low
// hsync/vsync produced by a sync generator (possibly from another clock
// domain). It checks every line and frame length against the expected
// timing, regenerates hpos/vpos/de, and declares lock after LOCK_FRAMES
// consecutive conforming frames.
//
// Ports:
//   clk       pixel clock, rising edge
//   rst_n     asynchronous active-low reset (async assert, sync release)
//   hsync_in  horizontal sync, active-low, may be asynchronous to clk
//   vsync_in  vertical sync, active-low, may be asynchronous to clk
//   hpos      regenerated pixel position, 0..H_TOTAL-1
//   vpos      regenerated line position, 0..V_TOTAL-1
//   de        display enable, aligned with hpos/vpos
//   locked    timing locked
//   h_meas    last measured line length in clocks (saturates at 1023)
//   v_meas    last measured frame length in lines (saturates at 1023)
//   sync_err  one-cycle pulse on any timing violation
//
// Optional build macro:
//   VGA_SYNC_RX_LOS_TIMEOUT_EN  enables the loss-of-signal timeout. When
//   2*H_TOTAL clocks pass without an hsync leading edge, the receiver drops
//   back to SEARCH.
// ---------------------------------------------------------------------------
module vga_sync_rx #(
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       de,
  output logic       locked,
  output logic [9:0] h_meas,
  output logic [9:0] v_meas,
  output logic       sync_err
);

  localparam logic [9:0] HVIS  = 10'(H_VISIBLE);
  localparam logic [9:0] HSS   = 10'(H_SYNC_START);
  localparam logic [9:0] HLAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] HTOT  = 10'(H_TOTAL);
  localparam logic [9:0] VVIS  = 10'(V_VISIBLE);
  localparam logic [9:0] VSS   = 10'(V_SYNC_START);
  localparam logic [9:0] VLAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] VTOT  = 10'(V_TOTAL);
  localparam logic [9:0] SAT   = 10'd1023;
  localparam logic [3:0] LOCKN = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] good, good_n, good_inc;
  logic       bad_line, badl_n;
  logic       err_n;

  logic       hs_s1, hs_s2, hs_prev;
  logic       vs_s1, vs_s2, vs_prev;
  logic       h_edge, v_edge;

  logic [9:0] hpos_n, vpos_n;
  logic       h_wrap;
  logic [9:0] hcnt, lcnt;
  logic       h_seen;
  logic       line_bad, frame_bad;
  logic       los_fire;

  // Two-flop synchronizers plus a previous-value flop per sync input.
  // All flops reset to 1 (sync inactive), so a reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1   <= 1'b1;
      hs_s2   <= 1'b1;
      hs_prev <= 1'b1;
      vs_s1   <= 1'b1;
      vs_s2   <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      hs_s1   <= hsync_in;
      hs_s2   <= hs_s1;
      hs_prev <= hs_s2;
      vs_s1   <= vsync_in;
      vs_s2   <= vs_s1;
      vs_prev <= vs_s2;
    end
  end

  // Leading (falling) edges of the active-low syncs.
  assign h_edge = hs_prev & ~hs_s2;
  assign v_edge = vs_prev & ~vs_s2;

  // Next-state position counters. A sync edge re-phases the counter to the
  // sync start position. Otherwise the counters free-run. A V_EDGE wins
  // over the line increment caused by an hpos wrap.
  always_comb begin
    hpos_n = hpos + 10'd1;
    h_wrap = 1'b0;
    if (h_edge) begin
      hpos_n = HSS;
    end else if (hpos == HLAST) begin
      hpos_n = '0;
      h_wrap = 1'b1;
    end

    vpos_n = vpos;
    if (v_edge) begin
      vpos_n = VSS;
    end else if (h_wrap) begin
      vpos_n = (vpos == VLAST) ? 10'd0 : vpos + 10'd1;
    end
  end

  // Position registers and display enable. The de output uses the
  // next-state position and lock state, so it lines up with hpos/vpos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos <= '0;
      vpos <= '0;
      de   <= 1'b0;
    end else begin
      hpos <= hpos_n;
      vpos <= vpos_n;
      de   <= (state_n == LOCKED) && (hpos_n < HVIS) && (vpos_n < VVIS);
    end
  end

  // Line and frame length measurement. When H_EDGE and V_EDGE coincide,
  // that H_EDGE belongs to the new frame, so lcnt restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt   <= '0;
      lcnt   <= '0;
      h_meas <= '0;
      v_meas <= '0;
      h_seen <= 1'b0;
    end else begin
      if (h_edge) begin
        h_meas <= hcnt;
        hcnt   <= 10'd1;
        h_seen <= 1'b1;
      end else if (hcnt != SAT) begin
        hcnt <= hcnt + 10'd1;
      end

      if (v_edge) begin
        v_meas <= lcnt;
        lcnt   <= h_edge ? 10'd1 : 10'd0;
      end else if (h_edge && (lcnt != SAT)) begin
        lcnt <= lcnt + 10'd1;
      end
    end
  end

  // The first H_EDGE after reset closes a line of unknown start, so it is
  // not checked. A frame is bad on a wrong line count or on any bad line
  // since the previous V_EDGE, including one ending in this same cycle.
  assign line_bad  = h_edge && h_seen && (hcnt != HTOT);
  assign frame_bad = (lcnt != VTOT) || bad_line || line_bad;

`ifdef VGA_SYNC_RX_LOS_TIMEOUT_EN
  localparam logic [11:0] LOS_LAST = 12'(2 * H_TOTAL - 1);

  logic [11:0] los_cnt;
  logic        los_armed;

  // Loss-of-signal watchdog. It fires once when 2*H_TOTAL clocks pass
  // without an H_EDGE, then stays quiet until hsync comes back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      los_cnt   <= '0;
      los_armed <= 1'b0;
    end else if (h_edge) begin
      los_cnt   <= '0;
      los_armed <= 1'b1;
    end else if (los_fire) begin
      los_armed <= 1'b0;
    end else if (los_armed) begin
      los_cnt <= los_cnt + 12'd1;
    end
  end

  assign los_fire = los_armed && !h_edge && (los_cnt == LOS_LAST);
`else
  assign los_fire = 1'b0;
`endif

  // Lock FSM state register, good-frame counter, sticky bad-line flag and
  // the registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good     <= '0;
      bad_line <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_n;
      good     <= good_n;
      bad_line <= badl_n;
      sync_err <= err_n;
    end
  end

  // Lock FSM next-state logic. SEARCH only waits for a frame boundary.
  // MEASURE counts consecutive good frames. LOCKED falls back to MEASURE
  // on the first bad line or frame. A bad line and a bad frame in the same
  // cycle share one error pulse.
  always_comb begin
    state_n  = state;
    good_n   = good;
    badl_n   = bad_line;
    err_n    = 1'b0;
    good_inc = good + 4'd1;

    case (state)
      SEARCH: begin
        if (v_edge) begin
          state_n = MEASURE;
          good_n  = '0;
          badl_n  = 1'b0;
        end
      end
      MEASURE: begin
        if (line_bad) begin
          badl_n = 1'b1;
          err_n  = 1'b1;
        end
        if (v_edge) begin
          badl_n = 1'b0;
          if (frame_bad) begin
            good_n = '0;
            err_n  = 1'b1;
          end else begin
            good_n = good_inc;
            if (good_inc == LOCKN) begin
              state_n = LOCKED;
            end
          end
        end
      end
      LOCKED: begin
        if (line_bad) begin
          badl_n  = 1'b1;
          err_n   = 1'b1;
          state_n = MEASURE;
          good_n  = '0;
        end
        if (v_edge) begin
          badl_n = 1'b0;
          if (frame_bad) begin
            err_n   = 1'b1;
            state_n = MEASURE;
            good_n  = '0;
          end
        end
      end
      default: begin
        state_n = SEARCH;
        good_n  = '0;
        badl_n  = 1'b0;
      end
    endcase

    // A timeout overrides everything and restarts acquisition.
    if (los_fire) begin
      state_n = SEARCH;
      good_n  = '0;
      badl_n  = 1'b0;
      err_n   = (state != SEARCH);
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_sync_rx.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_rx
//
// Testbench for vga_sync_rx using a reduced timing (32x20 total) so that
// many frames fit in a short run. A reference generator drives the syncs,
// and a queue delays the generator counters by three clocks. The delayed
// values are the expected hpos/vpos.
// ---------------------------------------------------------------------------
module tb_vga_sync_rx;

  localparam int HV  = 16;
  localparam int HSS = 20;
  localparam int HT  = 32;
  localparam int VV  = 12;
  localparam int VSS = 14;
  localparam int VT  = 20;
  localparam int LF  = 2;
  localparam int HSW = 4;
  localparam int VSW = 2;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] hpos, vpos, h_meas, v_meas;
  logic       de, locked, sync_err;

  vga_sync_rx #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hpos(hpos), .vpos(vpos), .de(de), .locked(locked),
    .h_meas(h_meas), .v_meas(v_meas), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gh = 0, gv = 0;
  int short_v = -1;
  bit short_frame = 1'b0;
  bit silent = 1'b0;
  bit gen_en = 1'b0;
  int last_hfall = 0, last_vfall = 0, vfall_cnt = 0;
  int err_cnt = 0;
  int sb_h[$];
  int sb_v[$];
  int exp_h = 0, exp_v = 0;

  // Count every sync_err pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (sync_err) err_cnt++;
  end

  // Safety net so the run can never hang.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock: step the reference generator just after the rising
  // edge, drive the syncs, and push/pop the 3-clock position scoreboard.
  task automatic step();
    bit nh, nv;
    int llen, flen;
    @(posedge clk);
    #1;
    cyc++;
    if (gen_en) begin
      llen = (gv == short_v) ? HT - 1 : HT;
      flen = short_frame ? VT - 1 : VT;
      if (gh == llen - 1) begin
        if (gv == short_v) short_v = -1;
        gh = 0;
        if (gv == flen - 1) begin
          gv = 0;
          short_frame = 1'b0;
        end else begin
          gv++;
        end
      end else begin
        gh++;
      end
    end
    nh = silent || !(gh >= HSS && gh < HSS + HSW);
    nv = silent || !(gv >= VSS && gv < VSS + VSW);
    if (hsync_in && !nh) last_hfall = cyc;
    if (vsync_in && !nv) begin
      vfall_cnt++;
      last_vfall = cyc;
    end
    hsync_in = nh;
    vsync_in = nv;
    sb_h.push_back(gh);
    sb_v.push_back(gv);
    if (sb_h.size() > 3) begin
      exp_h = sb_h.pop_front();
      exp_v = sb_v.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({hpos, vpos} !== 20'd0) begin
      failures++;
      $display("[TB] FAIL reset_pos: hpos=%0d vpos=%0d expected 0 0", hpos, vpos);
    end
    checks++;
    if ({de, locked} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_flags: de=%0b locked=%0b expected 0 0", de, locked);
    end
    checks++;
    if ({h_meas, v_meas} !== 20'd0) begin
      failures++;
      $display("[TB] FAIL reset_meas: h_meas=%0d v_meas=%0d expected 0 0", h_meas, v_meas);
    end
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_err: sync_err=%0b expected 0", sync_err);
    end
    rst_n = 1'b1;
    repeat (2) step();
    gen_en = 1'b1;
  endtask

  // Wait for lock, counting vsync falls from the moment the task is called.
  // Returns the cycle at which locked rose and the cycle of the third fall.
  task automatic wait_lock(output int rise, output int v3);
    rise = -1;
    v3 = -1;
    vfall_cnt = 0;
    for (int i = 0; i < 6 * FRAME && rise < 0; i++) begin
      step();
      if (vfall_cnt == 3 && v3 < 0) v3 = last_vfall;
      if (locked === 1'b1) rise = cyc;
    end
  endtask

  task automatic test_lock();
    int rise, v3, e0;
    e0 = err_cnt;
    wait_lock(rise, v3);
    checks++;
    if (rise < 0 || rise !== v3 + 3) begin
      failures++;
      $display("[TB] FAIL lock_cycle: locked rose at cycle %0d expected %0d", rise, v3 + 3);
    end
    checks++;
    if (int'(h_meas) !== HT) begin
      failures++;
      $display("[TB] FAIL lock_h_meas: got %0d expected %0d", h_meas, HT);
    end
    checks++;
    if (int'(v_meas) !== VT) begin
      failures++;
      $display("[TB] FAIL lock_v_meas: got %0d expected %0d", v_meas, VT);
    end
    checks++;
    if (err_cnt !== e0) begin
      failures++;
      $display("[TB] FAIL lock_no_err: %0d pulses expected 0", err_cnt - e0);
    end
  endtask

  task automatic test_alignment();
    int hbad = 0, vbad = 0, debad = 0, decnt = 0, unlk = 0, e0;
    e0 = err_cnt;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (int'(hpos) !== exp_h) hbad++;
      if (int'(vpos) !== exp_v) vbad++;
      if (de !== (exp_h < HV && exp_v < VV)) debad++;
      if (de === 1'b1) decnt++;
      if (locked !== 1'b1) unlk++;
    end
    checks++;
    if (hbad !== 0) begin
      failures++;
      $display("[TB] FAIL align_hpos: %0d mismatching cycles expected 0", hbad);
    end
    checks++;
    if (vbad !== 0) begin
      failures++;
      $display("[TB] FAIL align_vpos: %0d mismatching cycles expected 0", vbad);
    end
    checks++;
    if (debad !== 0) begin
      failures++;
      $display("[TB] FAIL align_de: %0d mismatching cycles expected 0", debad);
    end
    checks++;
    if (decnt !== HV * VV) begin
      failures++;
      $display("[TB] FAIL de_count: got %0d expected %0d", decnt, HV * VV);
    end
    checks++;
    if (unlk !== 0 || err_cnt !== e0) begin
      failures++;
      $display("[TB] FAIL align_stable: unlocked cycles %0d err pulses %0d expected 0 0",
               unlk, err_cnt - e0);
    end
  endtask

  task automatic test_short_line();
    int e0, ecyc, efall, rise, v3;
    for (int i = 0; i < 2 * FRAME && gv != 2; i++) step();
    short_v = 5;
    e0 = err_cnt;
    ecyc = -1;
    efall = 0;
    for (int i = 0; i < 2 * FRAME && ecyc < 0; i++) begin
      step();
      if (sync_err === 1'b1) begin
        ecyc = cyc;
        efall = last_hfall;
      end
    end
    checks++;
    if (ecyc < 0 || ecyc !== efall + 3 || gv !== 6) begin
      failures++;
      $display("[TB] FAIL short_err_time: pulse at cycle %0d (line %0d) expected cycle %0d on line 6",
               ecyc, gv, efall + 3);
    end
    checks++;
    if (int'(h_meas) !== HT - 1) begin
      failures++;
      $display("[TB] FAIL short_h_meas: got %0d expected %0d", h_meas, HT - 1);
    end
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short_unlock: locked=%0b expected 0", locked);
    end
    wait_lock(rise, v3);
    checks++;
    if (rise < 0 || rise !== v3 + 3) begin
      failures++;
      $display("[TB] FAIL short_relock: locked at cycle %0d expected %0d", rise, v3 + 3);
    end
    checks++;
    if (err_cnt - e0 !== 2) begin
      failures++;
      $display("[TB] FAIL short_err_count: %0d pulses expected 2", err_cnt - e0);
    end
  endtask

  task automatic test_short_frame();
    int e0, ecyc, evf, mid_v, mid_l, rise, v3;
    short_frame = 1'b1;
    e0 = err_cnt;
    ecyc = -1;
    evf = -1;
    vfall_cnt = 0;
    for (int i = 0; i < 2 * FRAME && ecyc < 0; i++) begin
      step();
      if (sync_err === 1'b1) begin
        ecyc = cyc;
        evf = vfall_cnt;
      end
    end
    checks++;
    if (ecyc < 0 || int'(v_meas) !== VT - 1) begin
      failures++;
      $display("[TB] FAIL frame_v_meas: got %0d expected %0d", v_meas, VT - 1);
    end
    checks++;
    if (locked !== 1'b0 || evf !== 1) begin
      failures++;
      $display("[TB] FAIL frame_unlock: locked=%0b at vsync fall %0d expected 0 at 1", locked, evf);
    end
    mid_v = -1;
    mid_l = -1;
    rise = -1;
    v3 = -1;
    for (int i = 0; i < 6 * FRAME && rise < 0; i++) begin
      step();
      if (vfall_cnt == 2 && cyc == last_vfall + 3) begin
        mid_v = int'(v_meas);
        mid_l = int'(locked);
      end
      if (vfall_cnt == 3 && v3 < 0) v3 = last_vfall;
      if (locked === 1'b1) rise = cyc;
    end
    checks++;
    if (mid_v !== VT || mid_l !== 0) begin
      failures++;
      $display("[TB] FAIL frame_resume: v_meas=%0d locked=%0d expected %0d 0", mid_v, mid_l, VT);
    end
    checks++;
    if (rise < 0 || rise !== v3 + 3) begin
      failures++;
      $display("[TB] FAIL frame_relock: locked at cycle %0d expected %0d", rise, v3 + 3);
    end
    checks++;
    if (err_cnt - e0 !== 1) begin
      failures++;
      $display("[TB] FAIL frame_err_count: %0d pulses expected 1", err_cnt - e0);
    end
  endtask

  task automatic test_reset_midframe();
    int e0, rise, v3;
    for (int i = 0; i < 2 * FRAME && !(gv == 5 && gh == 2); i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hpos, vpos} !== 20'd0 || {h_meas, v_meas} !== 20'd0) begin
      failures++;
      $display("[TB] FAIL midreset_values: hpos=%0d vpos=%0d h_meas=%0d v_meas=%0d expected all 0",
               hpos, vpos, h_meas, v_meas);
    end
    checks++;
    if ({de, locked, sync_err} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL midreset_flags: de=%0b locked=%0b sync_err=%0b expected 0 0 0",
               de, locked, sync_err);
    end
    step();
    rst_n = 1'b1;
    e0 = err_cnt;
    wait_lock(rise, v3);
    checks++;
    if (rise < 0 || rise !== v3 + 3) begin
      failures++;
      $display("[TB] FAIL midreset_relock: locked at cycle %0d expected %0d", rise, v3 + 3);
    end
    checks++;
    if (err_cnt !== e0) begin
      failures++;
      $display("[TB] FAIL midreset_no_err: %0d pulses expected 0", err_cnt - e0);
    end
  endtask

  task automatic test_los();
    int e0, ecyc;
    e0 = err_cnt;
    ecyc = -1;
    silent = 1'b1;
    for (int i = 0; i < 5 * HT; i++) begin
      step();
      if (sync_err === 1'b1 && ecyc < 0) ecyc = cyc;
    end
`ifdef VGA_SYNC_RX_LOS_TIMEOUT_EN
    checks++;
    if (ecyc !== last_hfall + 3 + 2 * HT) begin
      failures++;
      $display("[TB] FAIL los_time: pulse at cycle %0d expected %0d", ecyc, last_hfall + 3 + 2 * HT);
    end
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("[TB] FAIL los_unlock: locked=%0b expected 0", locked);
    end
    checks++;
    if (err_cnt - e0 !== 1) begin
      failures++;
      $display("[TB] FAIL los_err_count: %0d pulses expected 1", err_cnt - e0);
    end
`else
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("[TB] FAIL silent_keep_lock: locked=%0b expected 1", locked);
    end
    checks++;
    if (err_cnt !== e0) begin
      failures++;
      $display("[TB] FAIL silent_no_err: %0d pulses (first at %0d) expected 0", err_cnt - e0, ecyc);
    end
`endif
  endtask

  initial begin
    $display("[TB] vga_sync_rx bench start");
    test_reset();
    test_lock();
    test_alignment();
    test_short_line();
    test_short_frame();
    test_reset_midframe();
    test_los();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receiving end of the 640x480@60 VGA timing interface: takes hsync/vsync as produced by the sync generator, checks them against expected timing, and regenerates hpos/vpos and a display-enable.
- Used by the on-chip self-check and capture logic to verify the generator, and to lock downstream logic onto an external timing source.
- Declares lock only after a programmable number of consecutive conforming frames.
- Flags every timing violation.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_SYNC_START, 656, pixel index of the first hsync-active pixel
- H_TOTAL, 800, pixels per line
- V_VISIBLE, 480, visible lines per frame
- V_SYNC_START, 490, line index of the first vsync-active line
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to assert locked (1..15)

Ports:
- clk  in  1  pixel clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- hsync_in  in  1  horizontal sync, active-low, may be asynchronous to clk
- vsync_in  in  1  vertical sync, active-low, may be asynchronous to clk
- hpos  out  10  regenerated pixel position, 0..H_TOTAL-1
- vpos  out  10  regenerated line position, 0..V_TOTAL-1
- de  out  1  display enable
- locked  out  1  timing locked
- h_meas  out  10  last measured line length in clocks, saturating at 1023
- v_meas  out  10  last measured frame length in lines, saturating at 1023
- sync_err  out  1  one-cycle pulse on any timing violation

Behaviour:
- Reset (async assert, sync release):
  - hpos=0, vpos=0, de=0, locked=0, h_meas=0, v_meas=0, sync_err=0.
  - Synchronizer flops = 1 (inactive).
  - FSM = SEARCH; good-frame count = 0.
- Input path:
  - Each sync input goes through a 2-flop synchronizer plus a previous-value flop.
  - Leading edge = synchronized value 0 while previous value 1 (H_EDGE, V_EDGE). Latency from pin to edge detect is 3 clocks.
- hpos:
  - On H_EDGE, hpos <= H_SYNC_START.
  - Else, if hpos == H_TOTAL-1, hpos <= 0.
  - Else hpos <= hpos+1.
  - Free-runs in all states.
- vpos:
  - On V_EDGE, vpos <= V_SYNC_START. V_EDGE has priority over the hpos-wrap increment.
  - Else, on hpos wrap: vpos <= 0 if vpos == V_TOTAL-1, else vpos+1.
- Line measurement:
  - hcnt increments every clock, saturating at 1023.
  - On H_EDGE: h_meas <= hcnt, hcnt <= 1.
  - A line is bad if h_meas != H_TOTAL. The first H_EDGE after reset or SEARCH is not checked.
- Frame measurement:
  - lcnt counts H_EDGEs, saturating at 1023.
  - On V_EDGE: v_meas <= lcnt, lcnt <= 0.
  - If H_EDGE and V_EDGE occur in the same cycle, the H_EDGE is counted into the new frame (lcnt <= 1).
  - Frame bad = v_meas != V_TOTAL, or any bad line since the previous V_EDGE (sticky, cleared at V_EDGE).
- FSM:
  - SEARCH: locked=0. On V_EDGE -> MEASURE, good=0, bad-line flag cleared.
  - MEASURE: on each V_EDGE:
    - good frame: good+1; if good+1 == LOCK_FRAMES -> LOCKED.
    - bad frame: good=0, stay in MEASURE.
  - LOCKED: locked=1. On any bad line (at its H_EDGE) or bad frame (at V_EDGE) -> MEASURE, good=0, locked drops the next cycle.
- sync_err:
  - Pulses for 1 cycle on each bad-line or bad-frame evaluation in MEASURE or LOCKED.
  - Never pulses in SEARCH.
  - A bad line and a bad frame in the same cycle produce one pulse.
- de: registered; de = locked && hpos < H_VISIBLE && vpos < V_VISIBLE, evaluated on the next-state hpos/vpos so it aligns with the hpos/vpos outputs.
- Reset mid-frame: all state returns to reset values immediately; relock requires a full SEARCH->MEASURE cycle.

Optional Feature:
- Macro: VGA_SYNC_RX_LOS_TIMEOUT_EN.
- With it defined:
  - Loss-of-signal counter clears on H_EDGE and otherwise increments.
  - Reaching 2*H_TOTAL clocks without an H_EDGE forces SEARCH, locked=0, good=0, and one sync_err pulse. Re-arms only after the next H_EDGE.
- Without it: no timeout. A silent input leaves the FSM in its current state and locked unchanged.

Test Plan:
- Drive standard 800x525 timing from a reference generator for 3 frames -> locked rises exactly at the 3rd V_EDGE (LOCK_FRAMES=2 plus the initial SEARCH edge); h_meas=800, v_meas=525; sync_err never pulses.
- After lock, compare regenerated hpos/vpos with the generator's counters delayed 3 clocks -> exact match; de high for exactly 640x480 clocks per frame.
- Shorten one line to 799 clocks while locked -> sync_err pulses once at that H_EDGE, locked drops, h_meas=799; relock after 2 clean frames.
- Send a frame of 524 lines -> v_meas=524, sync_err pulse, good count resets; a later frame of 525 lines resumes counting.
- Assert rst_n low mid-frame for 1 clock while locked -> all outputs 0 asynchronously; locked returns only after SEARCH plus 2 good frames.
- With VGA_SYNC_RX_LOS_TIMEOUT_EN, hold hsync_in high after lock -> locked drops and sync_err pulses 1600 clocks after the last H_EDGE. Without the macro -> locked stays 1.
